// File: rtl/axi4_burst_mem.sv
// AXI4 burst memory slave with independent read/write FSMs.
// First R beat RD_LAT+1 cycles after AR, then one beat/cycle under rready; W one beat/cycle under wvalid; B held until bready.
module axi4_burst_mem #(
   parameter int unsigned DATA_W    = 32,
   parameter logic [31:0] MEM_BYTES = 32'h0200_0000,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                awvalid,
   output logic                awready,
   input  logic [31:0]         awaddr,
   input  logic [7:0]          awlen,
   input  logic [1:0]          awburst,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   output logic                bvalid,
   input  logic                bready,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [31:0]         araddr,
   input  logic [7:0]          arlen,
   input  logic [1:0]          arburst,
   output logic                rvalid,
   input  logic                rready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast
);
   localparam int unsigned BPB      = DATA_W / 8;
   localparam int unsigned LSB      = $clog2(BPB);
   localparam int unsigned WORDS    = MEM_BYTES / BPB;
   localparam int unsigned IDX_W    = $clog2(WORDS);
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};
   localparam logic [1:0]  OKAY     = 2'b00;
   localparam logic [1:0]  SLVERR   = 2'b10;
   localparam logic [3:0]  LAT_INIT = 4'((RD_LAT == 0) ? 0 : RD_LAT - 1);

   logic [DATA_W-1:0] mem [WORDS];

   function automatic logic in_range(input logic [31:0] a);
      return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
   endfunction

   function automatic logic burst_bad(input logic [1:0] b, input logic [7:0] len);
      return (b == 2'b11) || ((b == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   endfunction

   // WRAP keeps the bits above the (len+1)-beat window and increments inside it
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [1:0] b);
      logic [31:0] mask;
      mask = (({24'b0, len} + 32'd1) << LSB) - 32'd1;
      case (b)
         2'b01:   next_addr = a + 32'(BPB);
         2'b10:   next_addr = (a & ~mask) | ((a + 32'(BPB)) & mask);
         default: next_addr = a;
      endcase
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> LSB);
   endfunction

   typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

   rstate_t           rstate_q, rstate_d;
   logic [31:0]       raddr_q, raddr_d;
   logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
   logic [1:0]        rburst_q, rburst_d;
   logic [3:0]        rlat_q, rlat_d;
   logic              rld, rld_err;
   logic [31:0]       rld_addr;
   logic [7:0]        rld_len, rld_beat;
   logic [1:0]        rld_burst;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic              rlast_q;

   always_comb begin
      rstate_d  = rstate_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rburst_d  = rburst_q;
      rbeat_d   = rbeat_q;
      rlat_d    = rlat_q;
      rld       = 1'b0;
      rld_addr  = raddr_q;
      rld_len   = rlen_q;
      rld_burst = rburst_q;
      rld_beat  = 8'd0;
      case (rstate_q)
         R_IDLE: if (arvalid) begin
            raddr_d  = araddr;
            rlen_d   = arlen;
            rburst_d = arburst;
            rbeat_d  = 8'd0;
            rlat_d   = LAT_INIT;
            if (RD_LAT == 0) begin
               rstate_d  = R_DATA;
               rld       = 1'b1;
               rld_addr  = araddr;
               rld_len   = arlen;
               rld_burst = arburst;
            end else begin
               rstate_d = R_LAT;
            end
         end
         R_LAT: begin
            if (rlat_q == 4'd0) begin
               rstate_d = R_DATA;
               rld      = 1'b1;
            end else begin
               rlat_d = rlat_q - 4'd1;
            end
         end
         R_DATA: if (rready) begin
            if (rlast_q) begin
               rstate_d = R_IDLE;
            end else begin
               raddr_d  = next_addr(raddr_q, rlen_q, rburst_q);
               rbeat_d  = rbeat_q + 8'd1;
               rld      = 1'b1;
               rld_addr = raddr_d;
               rld_beat = rbeat_d;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   assign rld_err = burst_bad(rld_burst, rld_len) || !in_range(rld_addr);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rstate_q <= R_IDLE;
         raddr_q  <= '0;
         rlen_q   <= '0;
         rburst_q <= '0;
         rbeat_q  <= '0;
         rlat_q   <= '0;
         rdata_q  <= '0;
         rresp_q  <= OKAY;
         rlast_q  <= 1'b0;
      end else begin
         rstate_q <= rstate_d;
         raddr_q  <= raddr_d;
         rlen_q   <= rlen_d;
         rburst_q <= rburst_d;
         rbeat_q  <= rbeat_d;
         rlat_q   <= rlat_d;
         if (rld) begin
            rdata_q <= rld_err ? '0 : mem[word_idx(rld_addr)];
            rresp_q <= rld_err ? SLVERR : OKAY;
            rlast_q <= (rld_beat == rld_len);
         end
      end
   end

   assign arready = (rstate_q == R_IDLE);
   assign rvalid  = (rstate_q == R_DATA);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rlast   = rlast_q;

   wstate_t     wstate_q, wstate_d;
   logic [31:0] waddr_q, waddr_d;
   logic [7:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [1:0]  wburst_q, wburst_d, bresp_q, bresp_d;
   logic        werr_q, werr_d;
   logic        wbeat_err, wfinal, mem_we;

   assign wbeat_err = burst_bad(wburst_q, wlen_q) || !in_range(waddr_q);
   assign wfinal    = (wbeat_q == wlen_q);

   always_comb begin
      wstate_d = wstate_q;
      waddr_d  = waddr_q;
      wlen_d   = wlen_q;
      wburst_d = wburst_q;
      wbeat_d  = wbeat_q;
      werr_d   = werr_q;
      bresp_d  = bresp_q;
      case (wstate_q)
         W_IDLE: if (awvalid) begin
            waddr_d  = awaddr;
            wlen_d   = awlen;
            wburst_d = awburst;
            wbeat_d  = 8'd0;
            werr_d   = 1'b0;
            wstate_d = W_DATA;
         end
         W_DATA: if (wvalid) begin
            werr_d = werr_q | wbeat_err | (wlast != wfinal);
            if (wfinal) begin
               wstate_d = W_RESP;
               bresp_d  = werr_d ? SLVERR : OKAY;
            end else begin
               waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
               wbeat_d = wbeat_q + 8'd1;
            end
         end
         W_RESP: if (bready) wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wstate_q <= W_IDLE;
         waddr_q  <= '0;
         wlen_q   <= '0;
         wburst_q <= '0;
         wbeat_q  <= '0;
         werr_q   <= 1'b0;
         bresp_q  <= OKAY;
      end else begin
         wstate_q <= wstate_d;
         waddr_q  <= waddr_d;
         wlen_q   <= wlen_d;
         wburst_q <= wburst_d;
         wbeat_q  <= wbeat_d;
         werr_q   <= werr_d;
         bresp_q  <= bresp_d;
      end
   end

   assign mem_we = (wstate_q == W_DATA) && wvalid && !wbeat_err;

   // Storage is deliberately outside reset so contents survive a reset pulse
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < BPB; b++) begin
            if (wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign awready = (wstate_q == W_IDLE);
   assign wready  = (wstate_q == W_DATA);
   assign bvalid  = (wstate_q == W_RESP);
   assign bresp   = bresp_q;

endmodule

// File: doc/axi4_burst_mem.md
AXI4_BURST_MEM -- requirements
Module: axi4_burst_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data bus width in bits (legal values 32 or 64).
REQ-002 The block SHALL have parameter MEM_BYTES, default 32'h0200_0000, meaning backing store size in bytes (power of two).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning first byte address decoded (aligned to MEM_BYTES).
REQ-004 The block SHALL have parameter RD_LAT, default 1, meaning idle cycles between AR accept and first R beat (0..15).
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-007 The block SHALL have the write-address ports awvalid in 1, awready out 1, awaddr in 32, awlen in 8 and awburst in 2: AW channel.
REQ-008 The block SHALL have the write-data ports wvalid in 1, wready out 1, wdata in DATA_W, wstrb in DATA_W/8 and wlast in 1: W channel.
REQ-009 The block SHALL have the write-response ports bvalid out 1, bready in 1 and bresp out 2: B channel.
REQ-010 The block SHALL have the read-address ports arvalid in 1, arready out 1, araddr in 32, arlen in 8 and arburst in 2: AR channel.
REQ-011 The block SHALL have the read-data ports rvalid out 1, rready in 1, rdata out DATA_W, rresp out 2 and rlast out 1: R channel.

Function
REQ-012 Storage SHALL be MEM_BYTES/(DATA_W/8) words, word index = (addr - BASE_ADDR) >> log2(DATA_W/8); low address bits are ignored (full-width beats only).
REQ-013 A beat address SHALL be in range iff BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES; an out-of-range beat returns resp 2'b10 (SLVERR), rdata 0, and performs no write.
REQ-014 Beat address advance: FIXED (2'b00) stays the same; INCR (2'b01) adds DATA_W/8; WRAP (2'b10) adds DATA_W/8 modulo (awlen+1)*DATA_W/8, aligned to that boundary.
REQ-015 A WRAP burst with len not in {1,3,7,15}, or burst type 2'b11, SHALL complete all beats with SLVERR and no writes.
REQ-016 The read FSM SHALL have states R_IDLE, R_LAT and R_DATA; arready = 1 only in R_IDLE; an AR handshake latches addr, len and burst.
REQ-017 After an AR handshake the read FSM SHALL wait RD_LAT cycles in R_LAT (RD_LAT = 0 skips R_LAT), then enter R_DATA with beat 0 registered.
REQ-018 In R_DATA, rvalid SHALL be 1, with rdata, rresp and rlast held stable until rready; rlast = 1 exactly on beat len.
REQ-019 On rvalid & rready & rlast the read FSM SHALL return to R_IDLE (arready = 1 on the next cycle); on a non-last handshake the next beat SHALL be presented on the next cycle (one beat per cycle when rready is held high).
REQ-020 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready = 1 only in W_IDLE; wready = 1 only in W_DATA; W data is not accepted before AW.
REQ-021 Each W handshake SHALL write only the byte lanes with wstrb set, at the current beat address, visible to reads starting the following cycle.
REQ-022 The write FSM SHALL leave W_DATA after beat awlen; bresp = SLVERR if any beat errored or wlast mismatched (wlast early, or missing on beat awlen), else OKAY.
REQ-023 In W_RESP, bvalid = 1 and bresp SHALL be stable until bready, then the FSM returns to W_IDLE.
REQ-024 Read and write FSMs SHALL be independent; a read of a word written in the same cycle returns the old data.
REQ-025 A burst crossing the top of memory SHALL return SLVERR on the out-of-range beats only; in-range beats complete normally.

Reset
REQ-026 While reset = 0: arready = 1, awready = 1, wready = 0, rvalid = 0, bvalid = 0, rlast = 0, rdata = 0, rresp = 0, bresp = 0; both FSMs are in IDLE.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no response issued; memory contents SHALL not be initialised or cleared by reset.

Verification
REQ-028 The bench SHALL cover an INCR write of len=3 to 0x8000_0000 with data 1,2,3,4, all strobes set, bready high -> one bvalid with OKAY; then an INCR read of len=3 -> 1,2,3,4 with rlast on beat 3 only, first rvalid RD_LAT+1 cycles after the AR handshake.
REQ-029 The bench SHALL cover a WRAP read, len=3, DATA_W=32, araddr=0x8000_0008 -> beat addresses 0x08, 0x0C, 0x00, 0x04.
REQ-030 The bench SHALL cover a single write of 0xAABBCCDD with wstrb=4'b0101 over 0x11223344 -> readback 0x11BB33DD.
REQ-031 The bench SHALL cover a read at BASE_ADDR+MEM_BYTES-4 with len=1 -> beat 0 OKAY, beat 1 SLVERR with rdata 0.
REQ-032 The bench SHALL cover an INCR write of len=2 with wlast asserted on beat 1 -> bresp=SLVERR after beat 2; and rready held low for 5 cycles -> rdata and rlast stable throughout.
REQ-033 The bench SHALL cover reset pulled low during R_DATA -> rvalid = 0 asynchronously and arready = 1; a subsequent read returns the correct data.
